perf_counter_bank: RTL
======================

# perf_counter_bank

Parametrised bank of memory-mapped performance counters: the multi-channel successor to the processor's single free-running cycle counter. Each channel counts cycles or external events in level or edge mode, wraps or saturates, raises a sticky overflow flag with optional interrupt, and can be captured atomically into snapshot registers. It sits on the data-memory bus beside data memory, decoded by the top level through `sel`, and is read and written with ordinary load/store instructions.

## Interface

Parameters:
- NCH, 4, number of counter channels (1..8)
- WIDTH, 32, counter width in bits (2..32); reads are zero-extended to 32 bits

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- event  input  NCH  per-channel event inputs, synchronous to clk; tie to 1 for cycle counting
- sel  input  1  bus select from top-level address decode
- we  input  1  write strobe (MemWrite); effective only when sel=1
- addr  input  7  byte address within block; bits [6:2] select word, [1:0] ignored
- wdata  input  32  write data
- rdata  output  32  read data, combinational
- irq  output  1  OR of enabled sticky overflow flags, registered

## Operation

Register map (word offsets):
- 0x00 CTRL: bit i = channel i enable; bit 16+i = channel i irq enable
- 0x04 MODE: bit i = saturate (1) / wrap (0); bit 16+i = edge (1) / level (0)
- 0x08 OVF: bit i sticky overflow; write 1 to clear, write 0 no effect
- 0x0C SNAP: any write copies all live counters into snapshot registers in one cycle; reads 0
- 0x10+4*i COUNT[i]: live value; write loads wdata[WIDTH-1:0]
- 0x30+4*i SNAPVAL[i]: snapshot value; read-only, writes ignored
- Bits for channels ≥ NCH, unmapped offsets, and unused CTRL/MODE bits read 0; writes to them are ignored.

Counting, per channel, per cycle:
- inc = CTRL enable & (level mode ? event[i] : event[i] & ~prev[i]); prev[i] registers event[i] every cycle regardless of enable.
- Wrap mode: all-ones + inc → 0, set OVF[i].
- Saturate mode: all-ones + inc → holds all-ones, set OVF[i] on every attempted increment at max.
- rdata = 0 when sel=0.

## Timing

- Reset (reset=0): all counters, snapshots, CTRL, MODE, OVF, prev, irq = 0 immediately and asynchronously. Release is sampled at the next rising edge. Assertion mid-count discards all state.
- Writes take effect at the rising edge where sel & we = 1. Readback of the new value is valid in the following cycle.
- Reads are zero-latency. rdata reflects register contents before the current edge, so a load in the same cycle as an increment returns the pre-increment value.
- Simultaneous COUNT write and increment: the write wins; the increment is lost and no overflow is generated.
- Simultaneous SNAP write and increment: the snapshot captures the pre-increment value; the live counter still increments.
- Simultaneous overflow set and W1C clear of the same bit: set wins.
- Edge mode sees a rising edge only after one cycle with the input low. An event held high through reset release does not count.
- irq = |(OVF & CTRL[16+:NCH]) registered: it asserts one cycle after OVF sets (or the irq enable is written) and drops one cycle after clear.
- Disabling a channel freezes its value. Re-enabling resumes counting on the next qualifying cycle.

## Test plan

- Reset, then read every offset → all 0, irq=0. Then write CTRL=0x1 with event[0]=1 for 10 cycles → COUNT[0]=10.
- WIDTH=8, wrap mode: load COUNT[1]=0xFE, enable with event high for 3 cycles → COUNT[1]=0x01, OVF=0x2. With CTRL[17]=1, irq is 1 one cycle after the wrap. W1C OVF=0x2 → OVF=0, irq=0 next cycle.
- WIDTH=8, saturate mode: load COUNT[2]=0xFD, 5 events → COUNT[2]=0xFF, OVF[2]=1. Write OVF=0x4 in the same cycle as a further event at max → OVF[2] remains 1.
- Edge mode: event[3] pattern 0,1,1,1,0,1,0,1 → COUNT[3]=3. Level mode with the same pattern → 5.
- Write SNAP while all channels increment → each SNAPVAL[i] equals the pre-edge COUNT[i], and the live counters are one higher. Writes to SNAPVAL leave it unchanged.
- Write COUNT[0]=0x55 in the same cycle as an increment → COUNT[0]=0x55. Pulse reset low mid-count for a partial cycle → all registers read 0 immediately.

Source files
------------

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - memory-mapped bank of wrap/saturate performance counters with snapshot and irq
module perf_counter_bank #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   events,
    input  logic             sel,
    input  logic             we,
    input  logic [6:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam logic [4:0] W_CTRL = 5'd0;
    localparam logic [4:0] W_MODE = 5'd1;
    localparam logic [4:0] W_OVF  = 5'd2;
    localparam logic [4:0] W_SNAP = 5'd3;
    localparam int         W_CNT  = 4;
    localparam int         W_SNPV = 12;

    logic [4:0]       word;
    logic             wr;
    logic [NCH-1:0]   ctrl_en;
    logic [NCH-1:0]   ctrl_ie;
    logic [NCH-1:0]   mode_sat;
    logic [NCH-1:0]   mode_edge;
    logic [NCH-1:0]   ovf;
    logic [NCH-1:0]   prev;
    logic [WIDTH-1:0] cnt  [NCH];
    logic [WIDTH-1:0] snap [NCH];

    logic [NCH-1:0]   cnt_wr;
    logic [NCH-1:0]   inc;
    logic [NCH-1:0]   at_max;
    logic [NCH-1:0]   ovf_set;
    logic [NCH-1:0]   ovf_clr;

    // Byte lanes and the write-data bits beyond the mapped fields are intentionally ignored.
    logic unused;
    assign unused = ^{addr[1:0], wdata};

    assign word = addr[6:2];
    assign wr   = sel & we;

    // Per-channel increment qualification; a COUNT write suppresses both the increment and its overflow.
    always_comb begin
        cnt_wr  = '0;
        inc     = '0;
        at_max  = '0;
        ovf_set = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_wr[i]  = wr && (word == 5'(W_CNT + i));
            inc[i]     = ctrl_en[i] & (mode_edge[i] ? (events[i] & ~prev[i]) : events[i]);
            at_max[i]  = (cnt[i] == {WIDTH{1'b1}});
            ovf_set[i] = inc[i] & at_max[i] & ~cnt_wr[i];
        end
        ovf_clr = (wr && word == W_OVF) ? wdata[NCH-1:0] : '0;
    end

    // Control, mode, sticky overflow, edge history and the registered interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en   <= '0;
            ctrl_ie   <= '0;
            mode_sat  <= '0;
            mode_edge <= '0;
            ovf       <= '0;
            prev      <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr && word == W_CTRL) begin
                ctrl_en <= wdata[NCH-1:0];
                ctrl_ie <= wdata[16 +: NCH];
            end
            if (wr && word == W_MODE) begin
                mode_sat  <= wdata[NCH-1:0];
                mode_edge <= wdata[16 +: NCH];
            end
            // Set is OR-ed after the clear so a simultaneous overflow survives W1C.
            ovf  <= (ovf & ~ovf_clr) | ovf_set;
            prev <= events;
            irq  <= |(ovf & ctrl_ie);
        end
    end

    // Live counters and snapshot registers; snapshot takes the pre-edge live value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i]  <= '0;
                snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr && word == W_SNAP) begin
                    snap[i] <= cnt[i];
                end
                if (cnt_wr[i]) begin
                    cnt[i] <= wdata[WIDTH-1:0];
                end else if (inc[i]) begin
                    if (!at_max[i]) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end else if (!mode_sat[i]) begin
                        cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Zero-latency read mux; unmapped words and unused bits return 0.
    always_comb begin
        rdata = '0;
        if (sel) begin
            if (word == W_CTRL) begin
                rdata[NCH-1:0]  = ctrl_en;
                rdata[16 +: NCH] = ctrl_ie;
            end
            if (word == W_MODE) begin
                rdata[NCH-1:0]  = mode_sat;
                rdata[16 +: NCH] = mode_edge;
            end
            if (word == W_OVF) begin
                rdata[NCH-1:0] = ovf;
            end
            for (int i = 0; i < NCH; i++) begin
                if (word == 5'(W_CNT + i)) begin
                    rdata[WIDTH-1:0] = cnt[i];
                end
                if (word == 5'(W_SNPV + i)) begin
                    rdata[WIDTH-1:0] = snap[i];
                end
            end
        end
    end

endmodule
